// File: rtl/mdu_iterative.sv
// mdu_iterative: RV32M multiply/divide unit, shift-add / restoring, one bit per cycle.
// Define MDU_FAST_MUL_EN to replace the multiply loop with a single-cycle multiplier.
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int DW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op;
  logic             neg;
  logic [DW-1:0]    acc;
  logic [WIDTH-1:0] opb;

  logic             a_sg;
  logic             b_sg;
  logic             a_neg;
  logic             b_neg;
  logic             neg_in;
  logic [WIDTH-1:0] ma_in;
  logic [WIDTH-1:0] mb_in;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] special_res;

  always_comb begin
    a_sg = 1'b0;
    b_sg = 1'b0;
    unique case (1'b1)
      funct3 == 3'b001,
      funct3 == 3'b100,
      funct3 == 3'b110: begin
        a_sg = 1'b1;
        b_sg = 1'b1;
      end
      funct3 == 3'b010: a_sg = 1'b1;
      default: ;
    endcase
    a_neg  = a_sg & src_a[WIDTH-1];
    b_neg  = b_sg & src_b[WIDTH-1];
    ma_in  = a_neg ? -src_a : src_a;
    mb_in  = b_neg ? -src_b : src_b;
    // remainder follows the dividend; everything else the xor
    neg_in = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    div_zero = funct3[2] & (src_b == ZERO);
    div_ovf  = funct3[2] & ~funct3[0]
             & (src_a == MIN) & (src_b == ONES);
    if (div_zero)
      special_res = funct3[1] ? src_a : ONES;
    else
      special_res = funct3[1] ? ZERO : src_a;
  end

  logic [WIDTH:0]   add_sum;
  logic [DW-1:0]    mul_nx;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_try;
  logic             q_bit;
  logic [DW-1:0]    div_nx;
  logic [DW-1:0]    step_nx;
  logic [DW-1:0]    prod_s;
  logic [WIDTH-1:0] quo_sel;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] div_res;

  always_comb begin
    add_sum = {1'b0, acc[DW-1:WIDTH]}
            + (acc[0] ? {1'b0, opb} : {1'b0, ZERO});
    mul_nx  = {add_sum, acc[WIDTH-1:1]};
    rem_sh  = {acc[DW-1:WIDTH], acc[WIDTH-1]};
    q_bit   = rem_sh >= {1'b0, opb};
    rem_try = rem_sh[WIDTH-1:0] - opb;
    div_nx  = {q_bit ? rem_try : rem_sh[WIDTH-1:0],
               acc[WIDTH-2:0], q_bit};
    step_nx = (state == S_DIV) ? div_nx : mul_nx;
    prod_s  = neg ? -mul_nx : mul_nx;
    mul_res = (op == 2'b00) ? prod_s[WIDTH-1:0]
                            : prod_s[DW-1:WIDTH];
    quo_sel = op[1] ? div_nx[DW-1:WIDTH] : div_nx[WIDTH-1:0];
    div_res = neg ? -quo_sel : quo_sel;
  end

`ifdef MDU_FAST_MUL_EN
  logic [DW-1:0]    fast_p;
  logic [DW-1:0]    fast_s;
  logic [WIDTH-1:0] fast_res;

  always_comb begin
    fast_p   = {ZERO, ma_in} * {ZERO, mb_in};
    fast_s   = neg_in ? -fast_p : fast_p;
    fast_res = (funct3[1:0] == 2'b00) ? fast_s[WIDTH-1:0]
                                      : fast_s[DW-1:WIDTH];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op     <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      opb    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op  <= funct3[1:0];
            neg <= neg_in;
            cnt <= '0;
            if (div_zero | div_ovf) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= S_DONE;
            end else if (funct3[2]) begin
              acc   <= {ZERO, ma_in};
              opb   <= mb_in;
              busy  <= 1'b1;
              state <= S_DIV;
            end else begin
`ifdef MDU_FAST_MUL_EN
              result <= fast_res;
              done   <= 1'b1;
              state  <= S_DONE;
`else
              acc   <= {ZERO, mb_in};
              opb   <= ma_in;
              busy  <= 1'b1;
              state <= S_MUL;
`endif
            end
          end
        end
        S_MUL, S_DIV: begin
          acc <= step_nx;
          cnt <= cnt + ONE;
          if (cnt == LAST) begin
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= (state == S_DIV) ? div_res : mul_res;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed vectors for mdu_iterative.
// Latency expectations follow MDU_FAST_MUL_EN when defined.
module tb_mdu_iterative;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_EDGES = 1;
  localparam int MUL_BUSY  = 0;
`else
  localparam int MUL_EDGES = 33;
  localparam int MUL_BUSY  = 32;
`endif
  localparam int DIV_EDGES = 33;
  localparam int DIV_BUSY  = 32;

  typedef struct packed {
    logic [2:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   funct3 = 3'b000;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mdu_iterative #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .funct3(funct3),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  // Issue one op, then scramble inputs; ends one edge after done (IDLE).
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] res,
                        output int edges, output int bcyc,
                        output logic done_after, output logic [W-1:0] held);
    @(negedge clk);
    start = 1'b1; funct3 = f; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = ~f;
    src_a = 32'hDEADBEEF; src_b = 32'h12345678;
    edges = 1; bcyc = 0;
    while (edges < 100) begin
      if (done) break;
      if (busy) bcyc++;
      @(posedge clk); #1;
      edges++;
    end
    res = result;
    @(posedge clk); #1;
    done_after = done;
    held = result;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL reset_done: got %b want 0", done);
    end
    n_cmp++;
    if (result !== 32'h0) begin
      n_bad++; $display("FAIL reset_result: got %h want 0", result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors(input string tag, input vec_t v[$],
                              input int exp_edges, input int exp_busy);
    logic [W-1:0] res, held;
    logic         da;
    int           edges, bcyc;
    foreach (v[i]) begin
      run_op(v[i].f, v[i].a, v[i].b, res, edges, bcyc, da, held);
      n_cmp++;
      if (res !== v[i].e) begin
        n_bad++;
        $display("FAIL %s[%0d]_result: got %h want %h", tag, i, res, v[i].e);
      end
      n_cmp++;
      if (edges !== exp_edges) begin
        n_bad++;
        $display("FAIL %s[%0d]_latency: got %0d want %0d", tag, i, edges, exp_edges);
      end
      n_cmp++;
      if (bcyc !== exp_busy) begin
        n_bad++;
        $display("FAIL %s[%0d]_busy: got %0d want %0d", tag, i, bcyc, exp_busy);
      end
      n_cmp++;
      if (da !== 1'b0) begin
        n_bad++; $display("FAIL %s[%0d]_done_pulse: got %b want 0", tag, i, da);
      end
      n_cmp++;
      if (held !== v[i].e) begin
        n_bad++;
        $display("FAIL %s[%0d]_held: got %h want %h", tag, i, held, v[i].e);
      end
    end
  endtask

  task automatic test_mul();
    vec_t v[$];
    v.push_back({3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB});
    v.push_back({3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
    v.push_back({3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    v.push_back({3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
    v.push_back({3'b001, 32'h80000000, 32'h00000007, 32'hFFFFFFFC});
    v.push_back({3'b001, 32'h80000000, 32'h80000000, 32'h40000000});
    v.push_back({3'b000, 32'h80000000, 32'h00000002, 32'h00000000});
    test_vectors("mul", v, MUL_EDGES, MUL_BUSY);
  endtask

  task automatic test_div();
    vec_t v[$];
    v.push_back({3'b100, 32'hFFFFFFEC, 32'h00000006, 32'hFFFFFFFD});
    v.push_back({3'b110, 32'hFFFFFFEC, 32'h00000006, 32'hFFFFFFFE});
    v.push_back({3'b101, 32'h00000014, 32'h00000006, 32'h00000003});
    v.push_back({3'b111, 32'h00000014, 32'h00000006, 32'h00000002});
    v.push_back({3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD});
    v.push_back({3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001});
    v.push_back({3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000});
    v.push_back({3'b111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F});
    test_vectors("div", v, DIV_EDGES, DIV_BUSY);
  endtask

  task automatic test_special();
    vec_t v[$];
    v.push_back({3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF});
    v.push_back({3'b111, 32'h00000005, 32'h00000000, 32'h00000005});
    v.push_back({3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    v.push_back({3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000});
    v.push_back({3'b100, 32'h00000009, 32'h00000000, 32'hFFFFFFFF});
    v.push_back({3'b110, 32'hFFFFFFF7, 32'h00000000, 32'hFFFFFFF7});
    test_vectors("special", v, 1, 0);
  endtask

  task automatic test_start_ignored();
    int   edges;
    logic got;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1; got = 1'b0;
    while (edges < 100) begin
      if (done) begin got = 1'b1; break; end
      start = (edges == 6);
      funct3 = 3'b000; src_a = 32'd3; src_b = 32'd4;
      @(posedge clk); #1;
      edges++;
    end
    n_cmp++;
    if (got !== 1'b1 || result !== 32'h0000000E) begin
      n_bad++;
      $display("FAIL ignore_mid_result: got %h (done %b) want 0000000e", result, got);
    end
    n_cmp++;
    if (edges !== DIV_EDGES) begin
      n_bad++;
      $display("FAIL ignore_mid_latency: got %0d want %0d", edges, DIV_EDGES);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_in_done: got busy %b done %b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL abort_busy_before: got %b want 1", busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_state: got busy %b done %b want 0 0", busy, done);
    end
    n_cmp++;
    if (result !== 32'h0) begin
      n_bad++; $display("FAIL abort_result: got %h want 0", result);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | done | busy;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL abort_no_done: got %b want 0", seen);
    end
  endtask

  task automatic test_rst_start();
    logic seen;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    funct3 = 3'b101; src_a = 32'd50; src_b = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    seen = done | busy;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | done | busy;
    end
    n_cmp++;
    if (seen !== 1'b0 || result !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_start: got activity %b result %h want 0 0", seen, result);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    v.push_back({3'b000, 32'h00000003, 32'h00000004, 32'h0000000C});
    v.push_back({3'b000, 32'h00000005, 32'h00000006, 32'h0000001E});
    test_vectors("b2b", v, MUL_EDGES, MUL_BUSY);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_start_ignored();
    test_reset_abort();
    test_rst_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
